// File: rtl/iob_native_mem_responder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// iob_native_mem_responder
//   Responder end of the iob native bus. One request at a time is accepted
//   from IDLE. A byte-strobed write or a word read is done on an internal
//   word-addressed RAM in the acceptance cycle. A single-cycle ready pulse
//   carrying rdata is returned LATENCY cycles after acceptance.
//
// Ports
//   clk      in   1          system clock, rising edge
//   rst      in   1          asynchronous active-high reset
//   valid    in   1          request valid, held by the initiator until ready
//   address  in   ADDR_W     byte address; word index = address[MEM_ADDR_W+1:2]
//   wdata    in   DATA_W     write data
//   wstrb    in   DATA_W/8   byte write strobes; all-zero means read
//   ready    out  1          single-cycle response pulse
//   rdata    out  DATA_W     read data (0 on write responses), held between pulses
// ---------------------------------------------------------------------------
module iob_native_mem_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic                  ready,
    output logic [DATA_W-1:0]     rdata
);

    localparam int STRB_W    = DATA_W / 8;
    localparam int MEM_DEPTH = 1 << MEM_ADDR_W;
    localparam int CNT_W     = 5;

    if ((LATENCY < 1) || (LATENCY > 16)) begin : g_latency_check
        $error("iob_native_mem_responder: LATENCY must be within 1..16");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    ready_q;
    logic [DATA_W-1:0]       rdata_q;
    logic [DATA_W-1:0]       hold_q;

    logic [DATA_W-1:0]       mem_q [0:MEM_DEPTH-1];

    logic [MEM_ADDR_W-1:0]   idx_s;
    logic                    accept_s;
    logic                    is_write_s;
    logic [DATA_W-1:0]       rd_word_s;
    logic [DATA_W-1:0]       resp_data_d;

    // Bits outside the word index are deliberately ignored (address aliasing).
    logic                    unused_addr_s;
    assign unused_addr_s = ^{address[ADDR_W-1:MEM_ADDR_W+2], address[1:0]};

    assign idx_s      = address[MEM_ADDR_W+1:2];
    assign accept_s   = (state_q == ST_IDLE) && valid && !rst;
    assign is_write_s = |wstrb;
    assign rd_word_s  = mem_q[idx_s];

    // Response payload captured at acceptance: pre-write word for reads, zero for writes.
    always_comb begin
        resp_data_d = {DATA_W{1'b0}};
        if (is_write_s) begin
            resp_data_d = {DATA_W{1'b0}};
        end else begin
            resp_data_d = rd_word_s;
        end
    end

    // Byte-lane RAM write, committed at the end of the acceptance cycle.
    always_ff @(posedge clk) begin
        if (accept_s && is_write_s) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem_q[idx_s][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Transaction FSM; ready_q is set on entry to RESP so it is high exactly in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            ready_q <= 1'b0;
            rdata_q <= {DATA_W{1'b0}};
            hold_q  <= {DATA_W{1'b0}};
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (valid) begin
                        cnt_q  <= CNT_W'(LATENCY - 1);
                        hold_q <= resp_data_d;
                        if (LATENCY == 1) begin
                            state_q <= ST_RESP;
                            ready_q <= 1'b1;
                            rdata_q <= resp_data_d;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Bus inputs are ignored here; the transaction completes regardless.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_RESP;
                        ready_q <= 1'b1;
                        rdata_q <= hold_q;
                    end
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                ST_RESP: begin
                    // valid seen here belongs to the completing request.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;

endmodule
